// File: rtl/accel_packetiser.sv
// Samples X/Y/Z on a fixed tick and streams a 10-byte framed packet
// (sync, sequence, payload, checksum) over a valid/ready byte interface.
module accel_packetiser #(
   parameter int unsigned SAMPLE_PERIOD = 1000000,
   parameter logic [7:0]  SYNC0         = 8'hA5,
   parameter logic [7:0]  SYNC1         = 8'h5A
) (
   input  logic        Clk,
   input  logic        nReset,
   input  logic        Enable,
   input  logic [15:0] X,
   input  logic [15:0] Y,
   input  logic [15:0] Z,
   output logic [7:0]  TxData,
   output logic        TxValid,
   input  logic        TxReady,
   output logic [7:0]  Dropped
);

   localparam logic [23:0] LAST = 24'(SAMPLE_PERIOD - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state_q;
   logic [23:0] cnt_q;
   logic [3:0]  idx_q;
   logic [3:0]  idx_d;
   logic [7:0]  seq_q;
   logic [7:0]  chk_q;
   logic [7:0]  chk_d;
   logic [7:0]  byte_d;
   logic [15:0] x_q;
   logic [15:0] y_q;
   logic [15:0] z_q;
   logic        tick;
   logic        snap;
   logic        drop;

   assign tick  = (cnt_q == LAST);
   assign snap  = tick && Enable && (state_q == IDLE);
   assign drop  = tick && Enable && (state_q == SEND);
   assign idx_d = idx_q + 4'd1;

   // Checksum covers the live sequence number and inputs at the snapshot edge
   assign chk_d = seq_q + X[15:8] + X[7:0] + Y[15:8] + Y[7:0]
                + Z[15:8] + Z[7:0];

   always_comb begin
      byte_d = SYNC0;
      case (idx_d)
         4'd1:    byte_d = SYNC1;
         4'd2:    byte_d = seq_q;
         4'd3:    byte_d = x_q[15:8];
         4'd4:    byte_d = x_q[7:0];
         4'd5:    byte_d = y_q[15:8];
         4'd6:    byte_d = y_q[7:0];
         4'd7:    byte_d = z_q[15:8];
         4'd8:    byte_d = z_q[7:0];
         4'd9:    byte_d = chk_q;
         default: byte_d = SYNC0;
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + 24'd1;
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Dropped <= '0;
      end else if (drop && (Dropped != 8'hFF)) begin
         Dropped <= Dropped + 8'd1;
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         TxValid <= 1'b0;
         TxData  <= '0;
         idx_q   <= '0;
         seq_q   <= '0;
         chk_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (snap) begin
                  x_q     <= X;
                  y_q     <= Y;
                  z_q     <= Z;
                  chk_q   <= chk_d;
                  idx_q   <= '0;
                  TxData  <= SYNC0;
                  TxValid <= 1'b1;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (TxReady) begin
                  if (idx_q == 4'd9) begin
                     TxValid <= 1'b0;
                     TxData  <= '0;
                     seq_q   <= seq_q + 8'd1;
                     state_q <= IDLE;
                  end else begin
                     idx_q  <= idx_d;
                     TxData <= byte_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accel_packetiser.sv
// Directed bench for accel_packetiser: framing, backpressure, overrun,
// enable gating, async reset mid-packet and sequence wrap.
module tb_accel_packetiser;

   logic        Clk = 1'b0;
   logic        nReset = 1'b0;
   logic        Enable = 1'b1;
   logic [15:0] X = 16'h1234;
   logic [15:0] Y = 16'hFF80;
   logic [15:0] Z = 16'h0100;
   logic [7:0]  TxData;
   logic        TxValid;
   logic        TxReady = 1'b0;
   logic [7:0]  Dropped;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] rx [10];
   int         rx_cyc;
   logic [7:0] golden [10] = '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34,
                               8'hFF, 8'h80, 8'h01, 8'h00, 8'hC6};

   accel_packetiser #(
      .SAMPLE_PERIOD(50),
      .SYNC0(8'hA5),
      .SYNC1(8'h5A)
   ) dut (
      .Clk(Clk),
      .nReset(nReset),
      .Enable(Enable),
      .X(X),
      .Y(Y),
      .Z(Z),
      .TxData(TxData),
      .TxValid(TxValid),
      .TxReady(TxReady),
      .Dropped(Dropped)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int i, input logic [7:0] s,
                                           input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic [15:0] z);
      logic [7:0] c;
      c = s + x[15:8] + x[7:0] + y[15:8] + y[7:0] + z[15:8] + z[7:0];
      case (i)
         0: return 8'hA5;
         1: return 8'h5A;
         2: return s;
         3: return x[15:8];
         4: return x[7:0];
         5: return y[15:8];
         6: return y[7:0];
         7: return z[15:8];
         8: return z[7:0];
         default: return c;
      endcase
   endfunction

   task automatic cmp_pkt(input string tag, input logic [7:0] s,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z);
      for (int i = 0; i < 10; i++)
         check($sformatf("%s[%0d]", tag, i), 32'(rx[i]),
               32'(exp_byte(i, s, x, y, z)));
   endtask

   // Releases reset on a falling edge and checks first-tick latency.
   task automatic reset_first();
      @(negedge Clk);
      check("rst_valid", 32'(TxValid), 32'd0);
      check("rst_data", 32'(TxData), 32'd0);
      check("rst_drop", 32'(Dropped), 32'd0);
      nReset = 1'b1;
      repeat (49) @(negedge Clk);
      check("pre_tick_valid", 32'(TxValid), 32'd0);
      @(negedge Clk);
      check("first_valid", 32'(TxValid), 32'd1);
      check("first_sync", 32'(TxData), 32'hA5);
   endtask

   // Entered and left on a falling edge. mode 0: ready high, 1: 1-in-3.
   task automatic recv(input int mode, input int en_off_at,
                       input int abort_at);
      int n = 0;
      int first = -1;
      int last = -1;
      bit hold = 0;
      bit done = 0;
      bit rdy;
      logic [7:0] prev = '0;
      for (int c = 0; c < 600 && n < 10 && !done; c++) begin
         if (hold) begin
            check("hold_valid", 32'(TxValid), 32'd1);
            check("hold_data", 32'(TxData), 32'(prev));
         end
         if (abort_at >= 0 && n == abort_at && TxValid) begin
            done = 1;
         end else begin
            if (TxValid && first < 0) first = c;
            rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            TxReady = rdy;
            if (TxValid && rdy) begin
               rx[n] = TxData;
               n++;
               last = c;
               if (n == en_off_at) Enable = 1'b0;
            end
            hold = TxValid && !rdy;
            prev = TxData;
            @(negedge Clk);
         end
      end
      rx_cyc = last - first + 1;
      if (!done) begin
         check("recv_bytes", 32'(n), 32'd10);
         check("idle_gap", 32'(TxValid), 32'd0);
      end
   endtask

   initial begin
      int quiet;

      // Basic packet and latency
      reset_first();
      recv(0, -1, -1);
      for (int i = 0; i < 10; i++)
         check($sformatf("basic[%0d]", i), 32'(rx[i]), 32'(golden[i]));
      check("basic_cycles", 32'(rx_cyc), 32'd10);

      // Backpressure
      recv(1, -1, -1);
      cmp_pkt("bp", 8'h01, X, Y, Z);
      check("bp_drop", 32'(Dropped), 32'd0);

      // Overrun: stall 120 cycles, inputs change mid-stall
      nReset = 1'b0;
      TxReady = 1'b0;
      reset_first();
      for (int i = 0; i < 120; i++) begin
         TxReady = 1'b0;
         if (i == 5) begin
            X = 16'hBEEF;
            Y = 16'h0001;
            Z = 16'h7F00;
         end
         check("stall_valid", 32'(TxValid), 32'd1);
         check("stall_data", 32'(TxData), 32'hA5);
         @(negedge Clk);
      end
      recv(0, -1, -1);
      cmp_pkt("ovr", 8'h00, 16'h1234, 16'hFF80, 16'h0100);
      check("ovr_drop", 32'(Dropped), 32'd2);
      recv(0, -1, -1);
      cmp_pkt("ovr_next", 8'h01, 16'hBEEF, 16'h0001, 16'h7F00);
      check("ovr_drop2", 32'(Dropped), 32'd2);

      // Async reset at byte index 6
      recv(0, -1, 6);
      check("mid_idx6", 32'(TxData), 32'(exp_byte(6, 8'h02, X, Y, Z)));
      #2 nReset = 1'b0;
      #1;
      check("arst_valid", 32'(TxValid), 32'd0);
      check("arst_drop", 32'(Dropped), 32'd0);
      check("arst_data", 32'(TxData), 32'd0);
      reset_first();
      recv(0, -1, -1);
      cmp_pkt("arst_pkt", 8'h00, X, Y, Z);

      // Enable gating
      nReset = 1'b0;
      reset_first();
      recv(0, 4, -1);
      cmp_pkt("en_pkt", 8'h00, X, Y, Z);
      quiet = 0;
      repeat (150) begin
         @(negedge Clk);
         if (TxValid) quiet++;
      end
      check("en_quiet", 32'(quiet), 32'd0);
      check("en_drop", 32'(Dropped), 32'd0);
      Enable = 1'b1;
      recv(0, -1, -1);
      cmp_pkt("en_next", 8'h01, X, Y, Z);

      // Sequence wrap over 257 packets
      X = 16'h8001;
      Y = 16'h7FFE;
      Z = 16'hC3C3;
      nReset = 1'b0;
      reset_first();
      for (int p = 0; p < 257; p++) begin
         recv(0, -1, -1);
         cmp_pkt($sformatf("wrap%0d", p), 8'(p), X, Y, Z);
      end
      check("wrap_drop", 32'(Dropped), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/accel_packetiser.md
Name: accel_packetiser

Overview:
- Downstream consumer of the ADXL345 SPI reader.
- Snapshots the reader's registered X, Y and Z words at a fixed rate.
- Frames each snapshot as a 10-byte packet: sync, sequence, payload, checksum.
- Streams the packet one byte at a time over a valid/ready interface to the UART transmitter, which carries it to the host.

Parameters:
- SAMPLE_PERIOD, 1000000: clock cycles between snapshot ticks (100 Hz at 100 MHz); legal range 16 to 2^24.
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.

Ports:
- Clk  input  1  system clock, rising-edge.
- nReset  input  1  reset, asynchronous, active-low.
- Enable  input  1  high permits new packets.
- X  input  16  accelerometer X, from the ADXL345 reader.
- Y  input  16  accelerometer Y.
- Z  input  16  accelerometer Z.
- TxData  output  8  byte to the UART transmitter.
- TxValid  output  1  TxData is valid.
- TxReady  input  1  transmitter accepts the byte.
- Dropped  output  8  saturating count of ticks skipped while busy.

Behaviour:
- Reset (nReset low, asynchronous): TxValid=0, TxData=0, Dropped=0, sequence=0, tick counter=0, state IDLE. The rest of the RTL is synchronous to Clk.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps to 0.
  - Tick asserted for one cycle when count==SAMPLE_PERIOD-1.
  - Runs regardless of Enable or state.
- Snapshot:
  - Taken on a tick cycle with Enable=1 and state IDLE.
  - X, Y, Z and the sequence number latched together on that edge.
  - Later input changes do not affect the packet.
- Packet byte order, index 0..9:
  - 0: SYNC0
  - 1: SYNC1
  - 2: SEQ
  - 3: X[15:8]
  - 4: X[7:0]
  - 5: Y[15:8]
  - 6: Y[7:0]
  - 7: Z[15:8]
  - 8: Z[7:0]
  - 9: CHK
- Checksum: CHK = sum of bytes 2..8 modulo 256; sync bytes excluded.
- Latency: TxValid=1 with byte 0 on the cycle immediately after the snapshot edge.
- State machine:
  - IDLE: TxValid=0. Qualified tick → SEND, index=0.
  - SEND: TxValid=1, TxData=byte[index].
    - On an edge with TxValid and TxReady both high, the byte transfers and index increments.
    - Transfer at index 9 → IDLE and sequence increments (8-bit, wraps 255→0).
- Handshake:
  - TxData and TxValid are registered.
  - While TxValid=1 and TxReady=0, TxData is held stable and TxValid is never withdrawn.
  - TxReady is ignored in IDLE.
- Back-to-back: IDLE lasts at least one cycle between packets. The minimum packet duration with TxReady tied high is 10 cycles, so SAMPLE_PERIOD>=16 always fits.
- Overrun:
  - A tick while in SEND with Enable=1 increments Dropped, saturating at 255.
  - The in-flight packet is unaffected.
  - Sequence does not increment for skipped ticks.
- Enable:
  - Low blocks new snapshots only; an in-flight packet completes.
  - A tick with Enable=0 is neither sent nor counted in Dropped.
- Simultaneous events: on a tick in the same cycle as the final byte transfer, state is still SEND, so the tick counts as dropped.
- Reset mid-packet: TxValid drops immediately, all state is cleared, and the partial packet is abandoned.

Test Plan:
- Basic packet:
  - SAMPLE_PERIOD=50, TxReady=1, Enable=1, X=16'h1234, Y=16'hFF80, Z=16'h0100.
  - Required: first packet A5 5A 00 12 34 FF 80 01 00 C6 on 10 consecutive cycles.
  - Required: TxValid rises the cycle after count 49.
- Backpressure:
  - TxReady toggling with a 1-in-3 duty cycle.
  - Required: identical byte sequence; TxData stable and TxValid high whenever TxReady=0.
- Sequence wrap:
  - Run 257 packets with constant inputs.
  - Required: SEQ goes 00..FF then 00 and 01; each CHK is correct for its SEQ.
- Overrun:
  - SAMPLE_PERIOD=50; TxReady held low for 120 cycles after the first packet starts.
  - Required: Dropped=2, packet bytes unchanged, next packet SEQ=01.
- Enable gating:
  - Deassert Enable at byte index 4.
  - Required: the packet completes to CHK; no further TxValid and Dropped unchanged over 3 periods.
  - Reassert Enable: next packet has SEQ=01.
- Reset mid-packet:
  - Assert nReset low (not aligned to Clk) at index 6.
  - Required: TxValid=0 and Dropped=0 immediately.
  - After release: first packet has SEQ=00 and starts after a full SAMPLE_PERIOD.
